// File: rtl/multi_ch_threshold_blinker_pkg.sv
// Purpose: shared state encoding and default sizing for the threshold blinker.
// Latency: n/a (types and constants only).
// Backpressure: n/a (no flow control; samples are consumed every valid cycle).
package multi_ch_blink_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    BLINK_ON  = 2'b01,
    BLINK_OFF = 2'b10
  } blink_state_t;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DATA_W = 12;
  localparam int DEF_CNT_W  = 24;

  // Channel index width; a single channel still gets a 1-bit index.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_ch_threshold_blinker_if.sv
// Purpose: ADC sample bus (valid, channel index, data) shared by producer and blinker.
// Latency: n/a (wires only).
// Backpressure: none; every cycle with adc_data_valid high carries one sample.
interface multi_ch_threshold_blinker_if #(
  parameter int NUM_CH = multi_ch_blink_pkg::DEF_NUM_CH,
  parameter int DATA_W = multi_ch_blink_pkg::DEF_DATA_W
);
  localparam int CH_W = multi_ch_blink_pkg::ch_w(NUM_CH);

  logic              adc_data_valid;
  logic [CH_W-1:0]   adc_ch;
  logic [DATA_W-1:0] adc_data;

  modport master (output adc_data_valid, output adc_ch, output adc_data);
  modport slave  (input  adc_data_valid, input  adc_ch, input  adc_data);
endinterface

// File: rtl/multi_ch_threshold_blinker_channel.sv
// Purpose: one channel's IDLE/BLINK_ON/BLINK_OFF FSM with phase counter (sticky when BLINK_LATCH_EN).
// Latency: qualified sample at edge N drives led/alarm from the state registered at edge N.
// Backpressure: none; a decision is taken every cycle.
module blink_channel
  import multi_ch_blink_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             smp_vld,   // qualified sample for this channel
  input  logic             smp_hi,    // sample > thresh_hi
  input  logic             smp_lo,    // sample < thresh_lo
  input  logic             clear,
  input  logic [CNT_W-1:0] eff_half,  // phase length, never zero
  output logic             led,
  output logic             alarm
);

  blink_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             enter, leave, phase_end;

  // State and phase counter registers, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: entry on high sample, clear/hysteresis exit, phase toggling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    enter   = smp_vld && smp_hi;
`ifdef BLINK_LATCH_EN
    leave   = 1'b0;
`else
    leave   = smp_vld && smp_lo && !smp_hi;
`endif
    // >= so a shortened blink_half ends an over-long phase immediately.
    phase_end = (cnt_q >= (eff_half - CNT_W'(1)));
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enter) state_d = BLINK_ON;
      end
      BLINK_ON, BLINK_OFF: begin
        if ((clear && !enter) || leave) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (phase_end) begin
          state_d = (state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are pure decodes of the registered state.
  always_comb begin
    led   = (state_q == BLINK_ON);
    alarm = (state_q != IDLE);
  end

endmodule

// File: rtl/multi_ch_threshold_blinker.sv
// Purpose: NUM_CH threshold alarms with blinking LEDs; sample decode + any_alarm (BLINK_LATCH_EN = sticky alarms).
// Latency: sample at edge N shows on led/alarm right after edge N; any_alarm same cycle as alarm.
// Backpressure: none; the blinker accepts a sample on every valid cycle.
module multi_ch_threshold_blinker
  import multi_ch_blink_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                             clk,
  input  logic                             reset,
  multi_ch_threshold_blinker_if.slave      adc,
  input  logic [DATA_W-1:0]                thresh_hi,
  input  logic [DATA_W-1:0]                thresh_lo,
  input  logic [CNT_W-1:0]                 blink_half,
  input  logic [NUM_CH-1:0]                clear,
  output logic [NUM_CH-1:0]                led,
  output logic [NUM_CH-1:0]                alarm,
  output logic                             any_alarm
);

  localparam int CH_W = ch_w(NUM_CH);

  logic             smp_hi, smp_lo;
  logic [CNT_W-1:0] eff_half;

  // Threshold compares and phase length are shared by all channels.
  always_comb begin
    smp_hi   = (adc.adc_data > thresh_hi);
    smp_lo   = (adc.adc_data < thresh_lo);
    eff_half = (blink_half == '0) ? CNT_W'(1) : blink_half;
  end

  // Out-of-range channel indices match no instance and are dropped.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    blink_channel #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .smp_vld  (adc.adc_data_valid && (adc.adc_ch == CH_W'(k))),
      .smp_hi   (smp_hi),
      .smp_lo   (smp_lo),
      .clear    (clear[k]),
      .eff_half (eff_half),
      .led      (led[k]),
      .alarm    (alarm[k])
    );
  end

  // Summary flag, decoded from the registered per-channel alarms.
  always_comb begin
    any_alarm = |alarm;
  end

endmodule

// File: tb/tb_multi_ch_threshold_blinker.sv
module tb_multi_ch_threshold_blinker;

  localparam int NCH  = 5;
  localparam int DW   = 12;
  localparam int CW   = 24;
  localparam int CHW  = 3;
`ifdef BLINK_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [DW-1:0]  thresh_hi, thresh_lo;
  logic [CW-1:0]  blink_half;
  logic [NCH-1:0] clear;
  logic [NCH-1:0] led, alarm;
  logic           any_alarm;

  multi_ch_threshold_blinker_if #(.NUM_CH(NCH), .DATA_W(DW)) adc ();

  multi_ch_threshold_blinker #(.NUM_CH(NCH), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .adc        (adc.slave),
    .thresh_hi  (thresh_hi),
    .thresh_lo  (thresh_lo),
    .blink_half (blink_half),
    .clear      (clear),
    .led        (led),
    .alarm      (alarm),
    .any_alarm  (any_alarm)
  );

  always #5 clk = ~clk;

  // Reference model: per channel, whether an alarm is active, whether the
  // current phase is the lit one, and how many cycles of it have elapsed.
  bit m_active [NCH];
  bit m_lit    [NCH];
  int m_elapsed[NCH];

  int checks = 0;
  int errors = 0;

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_active[k] = 0; m_lit[k] = 0; m_elapsed[k] = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_edge();
    int  eff;
    bit  q, hi, lo;
    if (reset) begin
      model_reset();
      return;
    end
    eff = (blink_half == 0) ? 1 : int'(blink_half);
    for (int k = 0; k < NCH; k++) begin
      q  = adc.adc_data_valid && (int'(adc.adc_ch) == k);
      hi = q && (int'(adc.adc_data) > int'(thresh_hi));
      lo = q && (int'(adc.adc_data) < int'(thresh_lo));
      if (!m_active[k]) begin
        if (hi) begin
          m_active[k] = 1; m_lit[k] = 1; m_elapsed[k] = 1;
        end
      end else if ((clear[k] && !hi) || (!LATCH && lo && !hi)) begin
        m_active[k] = 0; m_lit[k] = 0; m_elapsed[k] = 0;
      end else if (m_elapsed[k] >= eff) begin
        m_lit[k] = !m_lit[k]; m_elapsed[k] = 1;
      end else begin
        m_elapsed[k]++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [NCH-1:0] e_led, e_alarm;
    for (int k = 0; k < NCH; k++) begin
      e_led[k]   = m_active[k] && m_lit[k];
      e_alarm[k] = m_active[k];
    end
    chk({tag, ".led"},   32'(led),       32'(e_led));
    chk({tag, ".alarm"}, 32'(alarm),     32'(e_alarm));
    chk({tag, ".any"},   32'(any_alarm), 32'(|e_alarm));
  endtask

  task automatic idle_in();
    adc.adc_data_valid = 1'b0;
    adc.adc_ch         = '0;
    adc.adc_data       = '0;
    clear              = '0;
  endtask

  // One clock: edge, model update, sample outputs 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    idle_in();
  endtask

  task automatic sample(input int ch, input int data, input string tag);
    adc.adc_data_valid = 1'b1;
    adc.adc_ch         = CHW'(ch);
    adc.adc_data       = DW'(data);
    step(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    reset = 1'b1;
    thresh_hi = 12'd2047; thresh_lo = 12'd1000; blink_half = 24'd4;
    idle_in();
    model_reset();
    #3;
    check_all("reset");
    chk("reset.led_zero", 32'(led), 32'd0);
    run(2, "reset_hold");
    reset = 1'b0;

    // Entry on ch2 and the 4-high/4-low pattern.
    sample(2, 2048, "ch2_entry");
    chk("ch2_entry.led_const", 32'(led), 32'h4);
    run(17, "ch2_blink");

    // Equal to thresh_hi is not an alarm, one above is.
    sample(0, 2047, "ch0_eq");
    sample(0, 2048, "ch0_above");
    chk("ch0_above.alarm0", 32'(alarm[0]), 32'd1);

    // Hysteresis on ch1.
    sample(1, 3000, "ch1_entry");
    run(3, "ch1_blink");
    sample(1, 1500, "ch1_mid");
    sample(1, 1000, "ch1_eq_lo");
    run(2, "ch1_blink2");
    sample(1, 999, "ch1_below");
    chk("ch1_below.alarm1", 32'(alarm[1]), LATCH ? 32'd1 : 32'd0);
    clear = 5'b00010;
    step("ch1_clear");

    // Clear racing an above-threshold sample on ch3.
    sample(3, 3000, "ch3_entry");
    run(2, "ch3_blink");
    clear = 5'b01000;
    sample(3, 3000, "ch3_clear_and_hi");
    chk("ch3_clear_and_hi.alarm3", 32'(alarm[3]), 32'd1);
    clear = 5'b01000;
    step("ch3_clear");
    chk("ch3_clear.alarm3", 32'(alarm[3]), 32'd0);

    // Reblink from above on a blinking channel does not restart the phase.
    sample(2, 4000, "ch2_rehit");
    run(3, "ch2_after_rehit");

    // Zero blink_half toggles every cycle.
    clear = '1;
    step("clear_all");
    blink_half = 24'd0;
    sample(4, 4000, "ch4_entry_bh0");
    run(6, "ch4_bh0");

    // Long phase cut short by a smaller blink_half.
    clear = '1;
    step("clear_all2");
    blink_half = 24'd100;
    sample(0, 4000, "ch0_long");
    run(50, "ch0_long_phase");
    blink_half = 24'd3;
    step("ch0_shorten");
    chk("ch0_shorten.led0", 32'(led[0]), 32'd0);
    run(8, "ch0_short");

    // Out-of-range channel indices are ignored.
    sample(5, 4000, "ch5_ignored");
    sample(7, 4000, "ch7_ignored");

    // Randomised traffic.
    blink_half = 24'd3;
    for (int i = 0; i < 600; i++) begin
      adc.adc_data_valid = ($urandom_range(0, 3) != 0);
      adc.adc_ch         = CHW'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       adc.adc_data = DW'($urandom_range(2040, 2055));
        1:       adc.adc_data = DW'($urandom_range(995, 1005));
        default: adc.adc_data = DW'($urandom_range(0, 4095));
      endcase
      for (int k = 0; k < NCH; k++) clear[k] = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 49) == 0) blink_half = CW'($urandom_range(0, 6));
      step("rand");
    end

    // Asynchronous reset in the middle of BLINK_ON.
    clear = '1;
    step("clear_all3");
    blink_half = 24'd4;
    sample(2, 4000, "pre_reset_entry");
    run(1, "pre_reset_on");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    chk("async_reset.led_zero", 32'(led), 32'd0);
    step("reset_held");
    reset = 1'b0;
    sample(2, 1500, "post_reset_mid");
    sample(2, 2048, "post_reset_entry");
    run(3, "post_reset_blink");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
